// File: rtl/spart_tx.sv
// -----------------------------------------------------------------------------
// spart_tx : transmit half of the SPART.
//
// A one-entry holding register takes a byte from the bus side. The byte is
// then serialised onto txd as an 8N1 frame: one start bit, d0..d7 LSB first,
// then one stop bit. Bit timing comes from the shared baud_clk enable pulse.
// When the holding register is refilled before a stop bit ends, the next frame
// follows with no idle bit period.
//
// Ports:
//   clk      in   system clock, all state on rising edge
//   rst      in   asynchronous active-high reset
//   en       in   transmit enable; gates only the start of new frames
//   baud_clk in   one-clk-wide pulse per bit period
//   tx_data  in   [7:0] byte to send, sampled when tx_wr is accepted
//   tx_wr    in   write strobe, accepted only while tbr=1
//   txd      out  serial line, idle high
//   tbr      out  holding register empty
//   tx_busy  out  frame in progress on txd
// -----------------------------------------------------------------------------
module spart_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       baud_clk,
    input  logic [7:0] tx_data,
    input  logic       tx_wr,
    output logic       txd,
    output logic       tbr,
    output logic       tx_busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XMIT = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [7:0] r_hold_data;
    logic [7:0] w_hold_data_nxt;
    logic       r_hold_valid;
    logic       w_hold_valid_nxt;
    logic [9:0] r_shft;
    logic [9:0] w_shft_nxt;
    logic [3:0] r_bit_cnt;
    logic [3:0] w_bit_cnt_nxt;
    logic       w_load;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_data  <= '0;
            r_hold_valid <= 1'b0;
            r_shft       <= '1;
            r_bit_cnt    <= '0;
        end else begin
            r_hold_data  <= w_hold_data_nxt;
            r_hold_valid <= w_hold_valid_nxt;
            r_shft       <= w_shft_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
        end
    end

    // Next state and datapath updates
    always_comb begin
        w_state_nxt      = r_state;
        w_hold_data_nxt  = r_hold_data;
        w_hold_valid_nxt = r_hold_valid;
        w_shft_nxt       = r_shft;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_load           = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (baud_clk && r_hold_valid && en) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_XMIT;
                end
            end
            ST_XMIT: begin
                if (baud_clk) begin
                    if (r_bit_cnt < 4'd9) begin
                        w_shft_nxt    = {1'b1, r_shft[9:1]};
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end else if (r_hold_valid && en) begin
                        // Stop bit done and a byte is waiting: chain frames.
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // A load empties the holding register. A write in that same cycle
        // sees the registered hold_valid=1 and is dropped, so a byte never
        // goes from tx_data straight into the shifter.
        if (w_load) begin
            w_shft_nxt       = {1'b1, r_hold_data, 1'b0};
            w_bit_cnt_nxt    = '0;
            w_hold_valid_nxt = 1'b0;
        end else if (tx_wr && !r_hold_valid) begin
            w_hold_data_nxt  = tx_data;
            w_hold_valid_nxt = 1'b1;
        end
    end

    assign txd     = (r_state == ST_XMIT) ? r_shft[0] : 1'b1;
    assign tbr     = ~r_hold_valid;
    assign tx_busy = (r_state == ST_XMIT);

endmodule

// File: doc/spart_tx.md
# spart_tx

Serial transmit half of the SPART: accepts a byte from the bus-side interface into a one-entry holding register and serialises it onto `txd` as an 8N1 frame. The frame has a start bit, then 8 data bits LSB first, then one stop bit. Bit timing comes from the shared `baud_clk` enable pulse, the same pulse that paces the receive half. Back-to-back frames are sent with no idle gap when the holding register is refilled in time.

## Interface
Parameters:
- none (frame format fixed at 8 data bits, no parity, 1 stop bit)

Ports:
- `clk`  in  1  system clock; all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `en`  in  1  transmit enable; gates only the start of new frames
- `baud_clk`  in  1  one-`clk`-wide enable pulse per bit period, synchronous to `clk`
- `tx_data`  in  8  byte to transmit, sampled when `tx_wr` is accepted
- `tx_wr`  in  1  write strobe; accepted only in a cycle where `tbr`=1
- `txd`  out  1  serial line, idle high
- `tbr`  out  1  transmit buffer ready (holding register empty)
- `tx_busy`  out  1  frame in progress on `txd`

## Operation
- Holding register `hold_data[7:0]` with `hold_valid`; `tbr` = ~`hold_valid`.
- `tx_wr` with `tbr`=1: `hold_data`<=`tx_data`, `hold_valid`<=1. `tx_wr` with `tbr`=0 is ignored; the held byte is unchanged and no error flag is raised.
- 10-bit shift register `shft`, `txd` = `shft[0]` in XMIT, 1 in IDLE. 4-bit counter `bit_cnt` runs 0..9.
- FSM, 2 states:
  - IDLE → XMIT on `baud_clk` & `hold_valid` & `en`. Load `shft`<={1'b1, hold_data, 1'b0}, clear `hold_valid`, set `bit_cnt`=0.
  - XMIT, `baud_clk` & `bit_cnt`<9: `shft`<={1'b1, shft[9:1]}, `bit_cnt`++.
  - XMIT, `baud_clk` & `bit_cnt`==9 (stop bit done):
    - if `hold_valid` & `en`: reload as in IDLE and stay in XMIT (back-to-back);
    - else go to IDLE.
  - XMIT with no `baud_clk`: hold state.
- `tx_busy` = (state==XMIT).
- `en` deasserted mid-frame: the current frame completes. The held byte is kept and sent once `en` returns.
- Load and `tx_wr` in the same cycle: the load uses the registered `hold_valid`, so `tbr`=0 and the write is ignored. A write never passes through to `shft` in the cycle it is accepted.
- `rst` asserted anytime, including mid-frame: state=IDLE, `hold_valid`=0, `bit_cnt`=0, `shft`=all 1s. The frame is truncated and any held data is discarded.

## Timing
- Reset values: `txd`=1, `tbr`=1, `tx_busy`=0.
- `tx_wr` accepted at cycle N → `tbr`=0 from N+1.
- First `baud_clk` pulse at cycle M ≥ N+1 with `en`=1 → from M+1: `txd`=0 (start bit), `tx_busy`=1, `tbr`=1.
- Each bit lasts from the cycle after one `baud_clk` pulse through the next pulse inclusive. Bit order: start, d0..d7, stop.
- A frame spans exactly 10 `baud_clk` periods, counting from the load pulse to the pulse that ends the stop bit.
- Back-to-back: the next start bit begins the cycle after the stop bit's final pulse. There are zero idle bit periods.
- Idle return: `txd`=1 and `tx_busy`=0 from the cycle after the final pulse.
- `baud_clk` is assumed at most one pulse per `clk` cycle, and it is ignored in IDLE unless a load occurs.

## Test plan
- **Single byte:** reset, `en`=1, write 0xA5, `baud_clk` every 16 cycles.
  - `txd` per bit period: 0,1,0,1,0,0,1,0,1,1, then stays 1.
  - `tx_busy` high for exactly 160 cycles.
  - `tbr` returns to 1 one cycle after the load pulse.
- **Back-to-back:** write 0x00; after `tbr` rises, write 0xFF.
  - Line shows 0, 8×0, 1, 0, 8×1, 1 with no idle period between frames.
  - `tbr`=1 after the second load.
- **Write while full:**
  - Write 0x3C, then 0x99 while `tbr`=0 → only 0x3C is transmitted.
  - `tx_wr` in the same cycle as the load → that write is ignored.
- **Enable gating:** `en`=0, write 0x55.
  - `txd` stays 1 and `tbr`=0 over 20 pulses.
  - Raise `en` → 0x55 is sent starting on the next pulse.
  - Drop `en` mid-frame → that frame completes normally.
- **Reset mid-frame:** assert `rst` during bit d3 with a byte held.
  - Without waiting for a clock edge: `txd`=1, `tbr`=1, `tx_busy`=0.
  - After release, no residual frame and no held-byte transmission.
- **Loopback:** connect `txd` to the SPART receive path with the shared `baud_clk`, send 0x00, 0x7E, 0x81, 0xFF → all four bytes received intact.
